// File: rtl/aoi22_fault_test_driver.sv
// aoi22_fault_test_driver
//   Drives a fault-free and a fault-injected AOI22 cell with all 16 input
//   patterns. Each pattern is held for SETTLE_CYCLES, then the two cell
//   outputs are compared for one cycle. The results are a per-pattern
//   detection map, the number of detecting patterns and the first detecting
//   pattern.
//
// Parameters
//   SETTLE_CYCLES : cycles each pattern is held before sampling (1..15)
//
// Optional build macro
//   RESP_MISR_EN  : adds output signature[15:0]. This is a 16-bit response
//                   MISR with polynomial x^16+x^12+x^5+1 and seed 16'hFFFF.
//
// Ports
//   clk, rst_n           : clock (rising edge), async active-low reset
//   start                : one-cycle pulse; starts a run from IDLE or DONE
//   good_out, faulty_out : outputs of the fault-free / faulty AOI22 instances
//   A, B, C, D           : AOI22 inputs = pattern[3:0] (registered)
//   busy, done           : run in progress / results valid
//   detect_map           : bit i set when pattern i produced a mismatch
//   detect_cnt           : number of detecting patterns (0..16)
//   first_detect         : lowest detecting pattern index (0 if none)
//   detected             : any pattern detected the fault
//   signature            : response MISR value (RESP_MISR_EN only)
module aoi22_fault_test_driver #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        good_out,
  input  logic        faulty_out,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] detect_map,
  output logic [4:0]  detect_cnt,
  output logic [3:0]  first_detect,
  output logic        detected
`ifdef RESP_MISR_EN
  , output logic [15:0] signature
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

`ifdef RESP_MISR_EN
  // One MISR step: shift left. Feedback taps are bits 12 and 5. The
  // response bit enters at bit 0 together with the feedback.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic din);
    logic fb;
    fb = s[15];
    misr_step = {s[14:0], 1'b0} ^ ({16{fb}} & 16'h1020) ^ {15'd0, fb ^ din};
  endfunction

  logic [15:0] sig_q, sig_d;
`endif

  logic [1:0]  state_q, state_d;
  logic [3:0]  pattern_q, pattern_d;
  logic [3:0]  settle_q, settle_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] map_q, map_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  first_q, first_d;
  logic        detected_q, detected_d;
  logic        mismatch_s;

  // Next-state, pattern sequencing and result accumulation
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    settle_d   = settle_q;
    map_d      = map_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    mismatch_s = good_out ^ faulty_out;
`ifdef RESP_MISR_EN
    sig_d      = sig_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A new run clears every result and restarts at pattern 0
        if (start) begin
          map_d     = 16'h0000;
          cnt_d     = 5'd0;
          first_d   = 4'd0;
          pattern_d = 4'd0;
          settle_d  = 4'd0;
`ifdef RESP_MISR_EN
          sig_d     = 16'hFFFF;
`endif
          state_d   = ST_APPLY;
        end else begin
          state_d   = state_q;
        end
      end

      ST_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
`ifdef RESP_MISR_EN
        sig_d = misr_step(sig_q, faulty_out);
`endif
        if (mismatch_s) begin
          map_d[pattern_q] = 1'b1;
          cnt_d            = cnt_q + 5'd1;
          // cnt_q == 0 means no pattern has detected the fault yet in this run
          if (cnt_q == 5'd0) begin
            first_d = pattern_q;
          end else begin
            first_d = first_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
        // Explicit exit at 15; the pattern register never wraps inside a run
        if (pattern_q == 4'd15) begin
          state_d = ST_DONE;
        end else begin
          pattern_d = pattern_q + 4'd1;
          state_d   = ST_APPLY;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d == ST_APPLY) || (state_d == ST_SAMPLE);
    done_d     = (state_d == ST_DONE);
    detected_d = |map_d;
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pattern_q  <= 4'd0;
      settle_q   <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      map_q      <= 16'h0000;
      cnt_q      <= 5'd0;
      first_q    <= 4'd0;
      detected_q <= 1'b0;
`ifdef RESP_MISR_EN
      sig_q      <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      settle_q   <= settle_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      map_q      <= map_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      detected_q <= detected_d;
`ifdef RESP_MISR_EN
      sig_q      <= sig_d;
`endif
    end
  end

  // The pattern register changes only on APPLY entry. It reads 0000 after
  // reset and 1111 in DONE, so it drives the cell inputs directly.
  assign A            = pattern_q[3];
  assign B            = pattern_q[2];
  assign C            = pattern_q[1];
  assign D            = pattern_q[0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign detect_map   = map_q;
  assign detect_cnt   = cnt_q;
  assign first_detect = first_q;
  assign detected     = detected_q;
`ifdef RESP_MISR_EN
  assign signature    = sig_q;
`endif

endmodule

// File: tb/tb_aoi22_fault_test_driver.sv
module tb_aoi22_fault_test_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // DUT 1 uses SETTLE_CYCLES=1 and DUT 2 uses SETTLE_CYCLES=2
  logic rst1_n, rst2_n, start1, start2;
  logic a1, b1, c1, d1, busy1, done1, det1, good1, faulty1;
  logic a2, b2, c2, d2, busy2, done2, det2, good2, faulty2;
  logic [15:0] map1, map2;
  logic [4:0]  cnt1, cnt2;
  logic [3:0]  first1, first2;
  int unsigned mode1, mode2;
`ifdef RESP_MISR_EN
  logic [15:0] sig1, sig2;
`endif

  // Fault modes: 0 none, 1 output stuck-at-0, 2 output stuck-at-1, 3 input A stuck-at-0
  function automatic logic fault_model(input int unsigned mode, input logic a, b, c, d);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~(c & d);
      default: return ~((a & b) | (c & d));
    endcase
  endfunction

  assign good1   = ~((a1 & b1) | (c1 & d1));
  assign good2   = ~((a2 & b2) | (c2 & d2));
  assign faulty1 = fault_model(mode1, a1, b1, c1, d1);
  assign faulty2 = fault_model(mode2, a2, b2, c2, d2);

  aoi22_fault_test_driver #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1),
    .good_out(good1), .faulty_out(faulty1),
    .A(a1), .B(b1), .C(c1), .D(d1),
    .busy(busy1), .done(done1), .detect_map(map1), .detect_cnt(cnt1),
    .first_detect(first1), .detected(det1)
`ifdef RESP_MISR_EN
    , .signature(sig1)
`endif
  );

  aoi22_fault_test_driver #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2),
    .good_out(good2), .faulty_out(faulty2),
    .A(a2), .B(b2), .C(c2), .D(d2),
    .busy(busy2), .done(done2), .detect_map(map2), .detect_cnt(cnt2),
    .first_detect(first2), .detected(det2)
`ifdef RESP_MISR_EN
    , .signature(sig2)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 1) ? done1 : done2;
  endfunction

  // Pulse start for one cycle; t0 is the cycle index in which start is high
  task automatic pulse_start(input int sel, output int t0);
    @(posedge clk); #1;
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Wait (bounded) for done; lat = cycle of first done minus start cycle
  task automatic wait_done(input int sel, input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (get_done(sel)) begin
        lat = cyc - t0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_res1(input string tag, input logic [15:0] m, input logic [4:0] n,
                            input logic [3:0] f);
    check_val({tag, "_map"},   map1,   m);
    check_val({tag, "_cnt"},   cnt1,   n);
    check_val({tag, "_first"}, first1, f);
    check_val({tag, "_det"},   det1,   (m != 16'h0000));
    check_val({tag, "_abcd"},  {a1, b1, c1, d1}, 4'hF);
    check_val({tag, "_busy"},  busy1,  1'b0);
  endtask

  task automatic check_res2(input string tag, input logic [15:0] m, input logic [4:0] n,
                            input logic [3:0] f);
    check_val({tag, "_map"},   map2,   m);
    check_val({tag, "_cnt"},   cnt2,   n);
    check_val({tag, "_first"}, first2, f);
    check_val({tag, "_det"},   det2,   (m != 16'h0000));
  endtask

`ifdef RESP_MISR_EN
  function automatic logic [15:0] misr_model(input int unsigned mode);
    logic [15:0] s;
    logic [3:0]  p;
    logic        fb;
    s = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      p  = 4'(i);
      fb = s[15];
      s  = {s[14:0], 1'b0} ^ (fb ? 16'h1020 : 16'h0000);
      s[0] = fb ^ fault_model(mode, p[3], p[2], p[1], p[0]);
    end
    return s;
  endfunction
`endif

  initial begin
    int t0, lat;
    rst1_n = 1'b0; rst2_n = 1'b0;
    start1 = 1'b0; start2 = 1'b0;
    mode1  = 0;    mode2  = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_abcd",  {a1, b1, c1, d1}, 4'h0);
    check_val("rst_flags", {busy1, done1, det1}, 3'b000);
    check_val("rst_res",   {map1, cnt1, first1}, 25'd0);
    @(negedge clk);
    rst1_n = 1'b1; rst2_n = 1'b1;
    @(posedge clk); #1;
    check_val("idle_flags", {busy1, done1}, 2'b00);

    // Fault-free run: nothing detected, done 33 cycles after start
    mode1 = 0;
    pulse_start(1, t0);
    check_val("ff_busy", busy1, 1'b1);
    wait_done(1, t0, lat);
    check_val("ff_lat", lat, 33);
    check_res1("ff", 16'h0000, 5'd0, 4'd0);
`ifdef RESP_MISR_EN
    check_val("ff_sig", sig1, misr_model(0));
`endif

    // Back-to-back from DONE: output stuck-at-0
    mode1 = 1;
    pulse_start(1, t0);
    check_val("sa0_clr_map",  map1, 16'h0000);
    check_val("sa0_clr_done", done1, 1'b0);
    check_val("sa0_busy",     busy1, 1'b1);
    check_val("sa0_abcd0",    {a1, b1, c1, d1}, 4'h0);
    wait_done(1, t0, lat);
    check_val("sa0_lat", lat, 33);
    check_res1("sa0", 16'h0777, 5'd9, 4'd0);

    // Output stuck-at-1
    mode1 = 2;
    pulse_start(1, t0);
    check_val("sa1_clr_map", map1, 16'h0000);
    wait_done(1, t0, lat);
    check_res1("sa1", 16'hF888, 5'd7, 4'd3);

    // Input A stuck-at-0
    mode1 = 3;
    pulse_start(1, t0);
    wait_done(1, t0, lat);
    check_res1("asa0", 16'h7000, 5'd3, 4'd12);
`ifdef RESP_MISR_EN
    check_val("asa0_sig", sig1, misr_model(3));
`endif

    // SETTLE_CYCLES=2 with a second start while busy: the second start must be ignored
    mode2 = 2;
    pulse_start(2, t0);
    repeat (2) @(posedge clk);
    #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    check_val("s2_busy", busy2, 1'b1);
    wait_done(2, t0, lat);
    check_val("s2_lat", lat, 49);
    check_res2("s2", 16'hF888, 5'd7, 4'd3);

    // Reset in the middle of a run (at pattern 5) discards the partial results
    mode2 = 1;
    pulse_start(2, t0);
    for (int i = 0; i < 100; i++) begin
      if ({a2, b2, c2, d2} == 4'd5) break;
      @(posedge clk); #1;
    end
    check_val("mid_p5", {a2, b2, c2, d2}, 4'd5);
    rst2_n = 1'b0;
    #1;
    check_val("mid_rst_abcd",  {a2, b2, c2, d2}, 4'h0);
    check_val("mid_rst_flags", {busy2, done2, det2}, 3'b000);
    check_val("mid_rst_res",   {map2, cnt2, first2}, 25'd0);
    @(negedge clk);
    rst2_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("post_rst_idle", {busy2, done2, map2}, 18'd0);

    // A fresh run after the reset completes normally
    mode2 = 3;
    pulse_start(2, t0);
    wait_done(2, t0, lat);
    check_val("post_lat", lat, 49);
    check_res2("post", 16'h7000, 5'd3, 4'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aoi22_fault_test_driver.md
Name: aoi22_fault_test_driver

Overview:
Sequential test driver for the fault-injectable AOI22 cell. Drives the cell's four inputs with an exhaustive 16-pattern sequence. Compares the faulty instance's output against a fault-free instance's output on every pattern and builds a per-pattern detection map, detection count and first-detecting pattern. It sits upstream of both AOI22 instances (it drives their inputs) and downstream of them (it consumes their outputs).

Parameters:
SETTLE_CYCLES, 1, cycles each pattern is held before sampling; legal range 1..15.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run from IDLE or DONE
good_out  input  1  output of the fault-free AOI22 instance
faulty_out  input  1  output of the fault-injected AOI22 instance
A  output  1  AOI22 input A = pattern[3]
B  output  1  AOI22 input B = pattern[2]
C  output  1  AOI22 input C = pattern[1]
D  output  1  AOI22 input D = pattern[0]
busy  output  1  high while in APPLY or SAMPLE
done  output  1  high while in DONE
detect_map  output  16  bit i = 1 if pattern i produced a mismatch
detect_cnt  output  5  number of detecting patterns, 0..16
first_detect  output  4  lowest detecting pattern index; 0 if none
detected  output  1  OR-reduce of detect_map

Behaviour:
- Reset (async assert, sync release): state IDLE, pattern=0, settle counter=0, all outputs 0.
- States:
  - IDLE: on start, clear detect_map, detect_cnt, first_detect and pattern, then go to APPLY.
  - APPLY: A..D are driven from the registered pattern. The settle counter counts 0..SETTLE_CYCLES-1, then the state goes to SAMPLE.
  - SAMPLE (1 cycle): mismatch = good_out XOR faulty_out.
    - If mismatch: set detect_map[pattern] and increment detect_cnt.
    - If mismatch and no earlier detection in this run: first_detect = pattern.
    - If pattern==15, go to DONE. Otherwise increment pattern and go to APPLY.
  - DONE: results and done are held. On start, clear results, set pattern=0 and go to APPLY; done drops in the same cycle.
- Timing: each pattern takes SETTLE_CYCLES+1 cycles. If start is sampled in cycle T, done first goes high at T+1+16*(SETTLE_CYCLES+1).
- start while busy is ignored.
- A..D are registered and change only on the APPLY entry edge. They hold 1111 in DONE and 0000 after reset.
- The pattern counter does not wrap inside a run. The exit at 15 is explicit.
- detect_cnt saturates naturally at 16 (5 bits, no overflow).
- good_out and faulty_out are sampled only in SAMPLE and ignored in all other states.
- Reset mid-run aborts immediately. All results clear and no partial map is retained.

Optional Feature:
RESP_MISR_EN: compiled in, this adds output signature[15:0] and a 16-bit LFSR with polynomial x^16+x^12+x^5+1 and seed 0xFFFF.
- The seed is reloaded on each start.
- The LFSR shifts once per SAMPLE with faulty_out XORed into bit 0.
- signature holds its value in DONE.
Compiled out, the port and the logic are absent; all other behaviour is identical.

Test Plan:
- Fault-free (bench ties faulty_out=good_out=~((A&B)|(C&D))), SETTLE_CYCLES=1 -> detect_map=0x0000, detect_cnt=0, detected=0, first_detect=0, done at start+33.
- Output stuck-at-0 (faulty_out=0) -> detect_map=0x0777, detect_cnt=9, first_detect=0, detected=1.
- Output stuck-at-1 (faulty_out=1) -> detect_map=0xF888, detect_cnt=7, first_detect=3.
- Input A stuck-at-0 (faulty_out=~(C&D)) -> detect_map=0x7000, detect_cnt=3, first_detect=12.
- SETTLE_CYCLES=2; start pulsed again while busy, then rst_n pulsed low at pattern 5 -> second start ignored, done at start+49. After the reset: outputs 0, IDLE; a new start completes a normal run.
- Back-to-back: start in DONE with a different fault -> the previous map clears the cycle after start, and the new results are correct.
